// File: rtl/frmbuf_axi3_rd_splitter.sv
// rtl/frmbuf_axi3_rd_splitter.sv - AXI4 to AXI3 read burst splitter with DDR window remap
//
// Takes one AXI4 INCR read burst (up to 256 beats of 4 B) at a time from the
// framebuffer master and reissues it as AXI3 sub-bursts of at most 16 beats
// that never cross a 4 KB boundary. Addresses are remapped into the DDR window.
// Upstream rlast is regenerated from a beat count. R beats seen while idle are
// orphans from before a reset; they are accepted and dropped.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   s_axi_ar*            upstream AR (valid/ready/addr/len)
//   s_axi_r*             upstream R (valid/ready/data/resp/last)
//   m_axi_ar*            AXI3 AR (valid/ready/addr/len/size/burst)
//   m_axi_r*             AXI3 R (valid/ready/data/resp/last)
//   drop_pulse           high for each dropped orphan beat
module frmbuf_axi3_rd_splitter #(
    parameter logic [31:0] REMAP_BASE  = 32'h0FE0_0000,
    parameter int          WINDOW_BITS = 21,
    parameter int          MAX_OUTST   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [3:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    output logic        drop_pulse
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_R = 2'd2
    } state_t;

    localparam logic [3:0] MAX_OUTST_C = 4'(MAX_OUTST);

    state_t                 state_q, state_d;
    logic [3:0]             outst_q, outst_d;
    logic [WINDOW_BITS-1:0] addr_q, addr_d;
    logic [8:0]             issue_rem_q, issue_rem_d;
    logic [8:0]             r_rem_q, r_rem_d;

    logic [10:0] to_4k;
    logic [4:0]  beats;
    logic        up_ar_fire;
    logic        ar_fire;
    logic        r_fire;
    logic        rlast_fire;

    // Upper local address bits and the byte offset are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, s_axi_araddr[31:WINDOW_BITS], s_axi_araddr[1:0]};

    // Sub-burst size: remaining beats, capped at 16 and at the distance to
    // the next 4 KB page (1..1024 words). Derived only from flops, so the AR
    // payload holds while the slave stalls.
    assign to_4k = 11'd1024 - {1'b0, addr_q[11:2]};

    always_comb begin
        beats = 5'd16;
        if (issue_rem_q < 9'd16) begin
            beats = issue_rem_q[4:0];
        end
        if (to_4k < {6'd0, beats}) begin
            beats = to_4k[4:0];
        end
    end

    assign up_ar_fire = s_axi_arvalid && s_axi_arready;
    assign ar_fire    = m_axi_arvalid && m_axi_arready;
    assign r_fire     = (state_q != S_IDLE) && m_axi_rvalid && s_axi_rready;
    assign rlast_fire = r_fire && m_axi_rlast;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            outst_q     <= 4'd0;
            addr_q      <= '0;
            issue_rem_q <= 9'd0;
            r_rem_q     <= 9'd0;
        end else begin
            state_q     <= state_d;
            outst_q     <= outst_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            r_rem_q     <= r_rem_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        outst_d     = outst_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        r_rem_d     = r_rem_q;

        case (state_q)
            S_IDLE: begin
                if (up_ar_fire) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_fire && (issue_rem_q == {4'd0, beats})) begin
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (r_fire && (r_rem_q == 9'd1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (up_ar_fire) begin
            addr_d      = {s_axi_araddr[WINDOW_BITS-1:2], 2'b00};
            issue_rem_d = {1'b0, s_axi_arlen} + 9'd1;
            r_rem_d     = {1'b0, s_axi_arlen} + 9'd1;
        end

        // Window wrap falls out of the addr_q width.
        if (ar_fire) begin
            addr_d      = addr_q + {{(WINDOW_BITS-7){1'b0}}, beats, 2'b00};
            issue_rem_d = issue_rem_q - {4'd0, beats};
        end

        if (r_fire) begin
            r_rem_d = r_rem_q - 9'd1;
        end

        // Simultaneous issue and completion cancel out.
        case ({ar_fire, rlast_fire && (outst_q != 4'd0)})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
    end

    // Outputs
    always_comb begin
        s_axi_arready = (state_q == S_IDLE);
        m_axi_arvalid = (state_q == S_ISSUE) && (outst_q < MAX_OUTST_C);
        m_axi_araddr  = {REMAP_BASE[31:WINDOW_BITS], addr_q};
        m_axi_arlen   = 4'(beats - 5'd1);
        m_axi_arsize  = 3'b010;
        m_axi_arburst = 2'b01;
        s_axi_rdata   = m_axi_rdata;
        s_axi_rresp   = m_axi_rresp;

        if (state_q == S_IDLE) begin
            // No burst owns these beats: sink them.
            s_axi_rvalid = 1'b0;
            s_axi_rlast  = 1'b0;
            m_axi_rready = 1'b1;
            drop_pulse   = m_axi_rvalid;
        end else begin
            s_axi_rvalid = m_axi_rvalid;
            s_axi_rlast  = m_axi_rlast && (r_rem_q == 9'd1);
            m_axi_rready = s_axi_rready;
            drop_pulse   = 1'b0;
        end
    end

endmodule

// File: tb/tb_frmbuf_axi3_rd_splitter.sv
// tb/tb_frmbuf_axi3_rd_splitter.sv - randomized self-checking bench for frmbuf_axi3_rd_splitter
module tb_frmbuf_axi3_rd_splitter;

    localparam int MAX_OUTST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [3:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        drop_pulse;

    frmbuf_axi3_rd_splitter dut (
        .clk(clk), .rst(rst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    int errors = 0;
    int checks = 0;

    // stimulus knobs
    int rr_prob = 100;
    int ar_prob = 100;
    int r_prob  = 100;
    int ar_cap  = 1000;
    bit r_en    = 1'b1;

    // slave state
    logic [31:0] sq_addr[$];
    logic [3:0]  sq_len[$];
    int          s_beat = 0;

    // reference model state
    logic [31:0] exp_ar_a[$];
    logic [3:0]  exp_ar_l[$];
    beat_t       exp_beats[$];
    bit          busy = 1'b0;
    int          outst_b = 0;
    bit          arready_next = 1'b0;
    bit          ar_pend = 1'b0;
    logic [31:0] pend_a;
    logic [3:0]  pend_l;

    // observation logs
    logic [31:0] ar_log_a[$];
    logic [3:0]  ar_log_l[$];
    int          beat_cnt = 0;
    int          last_cnt = 0;
    int          drop_cnt = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Reference: split by plain arithmetic and list every upstream beat.
    task automatic build_model(input logic [31:0] araddr, input logic [7:0] arlen);
        int unsigned a, rem, n, pg;
        a   = araddr & 32'h001F_FFFC;
        rem = int'(arlen) + 1;
        for (int k = 0; k < rem; k++) begin
            beat_t b;
            int unsigned ba;
            ba     = (a + 4 * k) % 32'h0020_0000;
            b.data = pat(32'h0FE0_0000 | ba);
            b.resp = 2'(ba >> 4);
            b.last = (k == rem - 1);
            exp_beats.push_back(b);
        end
        while (rem > 0) begin
            pg = (4096 - (a % 4096)) / 4;
            n  = rem;
            if (n > 16) n = 16;
            if (n > pg) n = pg;
            exp_ar_a.push_back(32'h0FE0_0000 | a);
            exp_ar_l.push_back(4'(n - 1));
            a   = (a + 4 * n) % 32'h0020_0000;
            rem = rem - n;
        end
    endtask

    // AXI3 slave: samples handshakes at negedge, drives after posedge.
    initial begin
        bit r_hs;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            r_hs = m_axi_rvalid && m_axi_rready;
            if (m_axi_arvalid && m_axi_arready) begin
                sq_addr.push_back(m_axi_araddr);
                sq_len.push_back(m_axi_arlen);
            end
            if (r_hs && sq_addr.size() > 0) begin
                if (s_beat == int'(sq_len[0])) begin
                    s_beat = 0;
                    void'(sq_addr.pop_front());
                    void'(sq_len.pop_front());
                end else begin
                    s_beat++;
                end
            end
            @(posedge clk);
            #1;
            m_axi_arready = (sq_addr.size() < ar_cap) && ($urandom_range(99) < ar_prob);
            if (!(m_axi_rvalid && !r_hs)) begin
                if (r_en && sq_addr.size() > 0 && $urandom_range(99) < r_prob) begin
                    logic [31:0] ba;
                    ba           = sq_addr[0] + 32'(4 * s_beat);
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = pat(ba);
                    m_axi_rresp  = ba[5:4];
                    m_axi_rlast  = (s_beat == int'(sq_len[0]));
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end
        end
    end

    // Upstream R backpressure
    initial begin
        s_axi_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_axi_rready = ($urandom_range(99) < rr_prob);
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                exp_ar_a.delete();
                exp_ar_l.delete();
                exp_beats.delete();
                outst_b      = 0;
                ar_pend      = 1'b0;
                arready_next = 1'b0;
            end else begin
                if (arready_next) begin
                    chk("arready_after_last", 32'(s_axi_arready), 32'd1);
                    arready_next = 1'b0;
                end
                if (ar_pend) begin
                    chk("ar_hold_valid", 32'(m_axi_arvalid), 32'd1);
                    chk("ar_hold_addr", m_axi_araddr, pend_a);
                    chk("ar_hold_len", 32'(m_axi_arlen), 32'(pend_l));
                end
                if (busy && exp_ar_a.size() > 0)
                    chk("arvalid_vs_outst", 32'(m_axi_arvalid), 32'(outst_b < MAX_OUTST));
                else
                    chk("arvalid_quiet", 32'(m_axi_arvalid), 32'd0);
                if (m_axi_arvalid) begin
                    chk("arsize", 32'(m_axi_arsize), 32'd2);
                    chk("arburst", 32'(m_axi_arburst), 32'd1);
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_log_a.push_back(m_axi_araddr);
                    ar_log_l.push_back(m_axi_arlen);
                    if (exp_ar_a.size() == 0) begin
                        fail_now("unexpected_ar");
                    end else begin
                        chk("ar_addr", m_axi_araddr, exp_ar_a.pop_front());
                        chk("ar_len", 32'(m_axi_arlen), 32'(exp_ar_l.pop_front()));
                    end
                    outst_b++;
                end
                ar_pend = m_axi_arvalid && !m_axi_arready;
                pend_a  = m_axi_araddr;
                pend_l  = m_axi_arlen;

                if (busy) begin
                    chk("rvalid_pass", 32'(s_axi_rvalid), 32'(m_axi_rvalid));
                    chk("rready_mirror", 32'(m_axi_rready), 32'(s_axi_rready));
                    chk("drop_busy", 32'(drop_pulse), 32'd0);
                    if (m_axi_rvalid && s_axi_rready) begin
                        beat_cnt++;
                        if (s_axi_rlast) last_cnt++;
                        if (exp_beats.size() == 0) begin
                            fail_now("unexpected_beat");
                        end else begin
                            beat_t b;
                            b = exp_beats.pop_front();
                            chk("rdata", s_axi_rdata, b.data);
                            chk("rresp", 32'(s_axi_rresp), 32'(b.resp));
                            chk("rlast", 32'(s_axi_rlast), 32'(b.last));
                        end
                        if (m_axi_rlast && outst_b > 0) outst_b--;
                        if (exp_beats.size() == 0) begin
                            busy         = 1'b0;
                            arready_next = 1'b1;
                        end
                    end
                end else begin
                    chk("idle_s_rvalid", 32'(s_axi_rvalid), 32'd0);
                    chk("idle_m_rready", 32'(m_axi_rready), 32'd1);
                    chk("idle_drop", 32'(drop_pulse), 32'(m_axi_rvalid));
                    if (m_axi_rvalid) drop_cnt++;
                end

                if (s_axi_arvalid && s_axi_arready) begin
                    build_model(s_axi_araddr, s_axi_arlen);
                    busy = 1'b1;
                end
            end
        end
    end

    task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len);
        bit ok;
        ar_log_a.delete();
        ar_log_l.delete();
        beat_cnt = 0;
        last_cnt = 0;
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_axi_arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("timeout_upstream_ar");
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("timeout_burst_done");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_log(input string nm, input logic [31:0] a, input logic [3:0] l, input int idx);
        if (ar_log_a.size() > idx) begin
            chk({nm, "_addr"}, ar_log_a[idx], a);
            chk({nm, "_len"}, 32'(ar_log_l[idx]), 32'(l));
        end else begin
            fail_now({nm, "_missing"});
        end
    endtask

    initial begin
        bit ok;
        rst           = 1'b1;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_arready", 32'(s_axi_arready), 32'd1);
        chk("rst_m_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_drop", 32'(drop_pulse), 32'd0);
        chk("rst_s_rvalid", 32'(s_axi_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full 256-beat burst, no backpressure
        issue_ar(32'h0000_0100, 8'd255);
        wait_done();
        chk("t1_ar_count", 32'(ar_log_a.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check_log("t1", 32'h0FE0_0100 + 32'(i) * 32'h40, 4'd15, i);
        chk("t1_beats", 32'(beat_cnt), 32'd256);
        chk("t1_lasts", 32'(last_cnt), 32'd1);

        // 4 KB split, with backpressure everywhere
        rr_prob = 50; ar_prob = 60; r_prob = 70;
        issue_ar(32'h0000_0FE0, 8'd19);
        wait_done();
        chk("t2_ar_count", 32'(ar_log_a.size()), 32'd2);
        check_log("t2a", 32'h0FE0_0FE0, 4'd7, 0);
        check_log("t2b", 32'h0FE0_1000, 4'd11, 1);
        chk("t2_beats", 32'(beat_cnt), 32'd20);
        chk("t2_lasts", 32'(last_cnt), 32'd1);

        // Window wrap
        issue_ar(32'h001F_FFF0, 8'd7);
        wait_done();
        chk("t3_ar_count", 32'(ar_log_a.size()), 32'd2);
        check_log("t3a", 32'h0FFF_FFF0, 4'd3, 0);
        check_log("t3b", 32'h0FE0_0000, 4'd3, 1);
        chk("t3_beats", 32'(beat_cnt), 32'd8);

        // Outstanding limit with R held off
        rr_prob = 100; ar_prob = 100; r_prob = 100; r_en = 1'b0;
        issue_ar(32'h0000_0000, 8'd255);
        repeat (40) @(negedge clk);
        chk("t4_ar_capped", 32'(ar_log_a.size()), 32'd4);
        chk("t4_arvalid_low", 32'(m_axi_arvalid), 32'd0);
        r_en = 1'b1;
        wait_done();
        chk("t4_ar_count", 32'(ar_log_a.size()), 32'd16);
        chk("t4_beats", 32'(beat_cnt), 32'd256);

        // 50% upstream backpressure, then random bursts
        rr_prob = 50;
        issue_ar(32'h0000_2F00, 8'd63);
        wait_done();
        chk("t5_beats", 32'(beat_cnt), 32'd64);
        chk("t5_lasts", 32'(last_cnt), 32'd1);
        for (int n = 0; n < 6; n++) begin
            int len;
            ar_prob = 30 + int'($urandom_range(70));
            r_prob  = 30 + int'($urandom_range(70));
            len     = int'($urandom_range(255));
            issue_ar($urandom, 8'(len));
            wait_done();
            chk("rand_beats", 32'(beat_cnt), 32'(len + 1));
        end

        // Reset mid-burst with 3 sub-bursts outstanding, then drain orphans
        rr_prob = 100; ar_prob = 100; r_prob = 100; r_en = 1'b0; ar_cap = 3;
        issue_ar(32'h0004_0000, 8'd255);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sq_addr.size() == 3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("timeout_three_outstanding");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        drop_cnt = 0;
        ar_cap   = 1000;
        r_en     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sq_addr.size() == 0 && !m_axi_rvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("timeout_orphan_drain");
        chk("t6_drops", 32'(drop_cnt), 32'd48);
        issue_ar(32'h0000_0080, 8'd3);
        wait_done();
        chk("t6_ar_count", 32'(ar_log_a.size()), 32'd1);
        check_log("t6", 32'h0FE0_0080, 4'd3, 0);
        chk("t6_beats", 32'(beat_cnt), 32'd4);
        chk("t6_lasts", 32'(last_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
